// File: rtl/pattern_sender_pkg.sv
// Shared types and constants for the serial pattern transmitter.
package pattern_sender_pkg;

   localparam int PATTERN_W = 4;
   localparam logic [PATTERN_W-1:0] RESET_PATTERN = 4'b0001;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEND   = 2'd1,
      GAP    = 2'd2,
      FINISH = 2'd3
   } state_t;

   // Idle bits are the complement of the last pattern bit so a detector never sees a false match.
   function automatic logic idle_level(input logic [PATTERN_W-1:0] pat);
      return ~pat[0];
   endfunction

endpackage

// File: rtl/pattern_piso.sv
// 4-bit parallel-load, shift-left serializer; load has priority over shift.
module pattern_piso
   import pattern_sender_pkg::*;
(
   input  logic                 clock,
   input  logic                 rst_n,
   input  logic                 load,
   input  logic                 shift,
   input  logic [PATTERN_W-1:0] din,
   output logic                 msb
);

   logic [PATTERN_W-1:0] q_r;

   // Shift register: parallel load or shift toward the MSB
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         q_r <= RESET_PATTERN;
      end else if (load) begin
         q_r <= din;
      end else if (shift) begin
         q_r <= {q_r[PATTERN_W-2:0], 1'b0};
      end else begin
         q_r <= q_r;
      end
   end

   assign msb = q_r[PATTERN_W-1];

endmodule

// File: rtl/pattern_sender.sv
// Serial pattern transmitter, MSB first, repeated reps times.
// Optional inter-repetition idle gaps are built when PATTERN_SENDER_GAP_EN is defined.
module pattern_sender
   import pattern_sender_pkg::*;
#(
   parameter int REPS_W  = 4,
   parameter int GAP_LEN = 2
) (
   input  logic                 clock,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [PATTERN_W-1:0] pattern,
   input  logic [REPS_W-1:0]    reps,
   output logic                 ser_out,
   output logic                 ser_valid,
   output logic                 busy,
   output logic                 done
);

   localparam logic [1:0]        LAST_BIT = 2'(PATTERN_W - 1);
   localparam logic [REPS_W-1:0] ONE_REP  = REPS_W'(1);

   if (GAP_LEN < 1 || GAP_LEN > 15) begin : g_gap_len_check
      $error("pattern_sender: GAP_LEN must be within 1..15");
   end

   state_t               state_r, state_nx_s;
   logic [PATTERN_W-1:0] pat_r;
   logic [REPS_W-1:0]    cnt_r;
   logic [1:0]           bit_cnt_r;
   logic                 accept_s, last_bit_s, last_rep_s;
   logic                 load_s, shift_s, piso_msb_s;
   logic [PATTERN_W-1:0] load_data_s;
   logic                 ser_out_nx_s, ser_valid_nx_s, busy_nx_s, done_nx_s;

   assign accept_s    = start && ((state_r == IDLE) || (state_r == FINISH));
   assign last_bit_s  = (bit_cnt_r == LAST_BIT);
   assign last_rep_s  = (cnt_r == ONE_REP);
   assign load_s      = accept_s || ((state_r == SEND) && last_bit_s && !last_rep_s);
   assign load_data_s = accept_s ? pattern : pat_r;
   assign shift_s     = (state_r == SEND) && !load_s;

   pattern_piso u_piso (
      .clock (clock),
      .rst_n (rst_n),
      .load  (load_s),
      .shift (shift_s),
      .din   (load_data_s),
      .msb   (piso_msb_s)
   );

`ifdef PATTERN_SENDER_GAP_EN
   localparam logic [3:0] GAP_LAST = 4'(GAP_LEN - 1);

   logic [3:0] gap_cnt_r;
   logic       gap_last_s;

   assign gap_last_s = (gap_cnt_r == GAP_LAST);

   // Gap counter: counts idle bits while in GAP, cleared elsewhere
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         gap_cnt_r <= 4'd0;
      end else if ((state_r == GAP) && !gap_last_s) begin
         gap_cnt_r <= gap_cnt_r + 4'd1;
      end else begin
         gap_cnt_r <= 4'd0;
      end
   end
`endif

   // State register
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Next-state logic
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         IDLE, FINISH: begin
            if (start) begin
               state_nx_s = (reps == {REPS_W{1'b0}}) ? FINISH : SEND;
            end else begin
               state_nx_s = IDLE;
            end
         end
         SEND: begin
            if (last_bit_s && last_rep_s) begin
               state_nx_s = FINISH;
            end else if (last_bit_s) begin
`ifdef PATTERN_SENDER_GAP_EN
               state_nx_s = GAP;
`else
               state_nx_s = SEND;
`endif
            end else begin
               state_nx_s = SEND;
            end
         end
`ifdef PATTERN_SENDER_GAP_EN
         GAP: begin
            if (gap_last_s) begin
               state_nx_s = SEND;
            end else begin
               state_nx_s = GAP;
            end
         end
`endif
         default: state_nx_s = IDLE;
      endcase
   end

   // Latched pattern, remaining repetitions and bit position within the pattern
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         pat_r     <= RESET_PATTERN;
         cnt_r     <= {REPS_W{1'b0}};
         bit_cnt_r <= 2'd0;
      end else if (accept_s) begin
         pat_r     <= pattern;
         cnt_r     <= reps;
         bit_cnt_r <= 2'd0;
      end else if (state_r == SEND) begin
         bit_cnt_r <= bit_cnt_r + 2'd1;
         if (last_bit_s) begin
            cnt_r <= cnt_r - ONE_REP;
         end else begin
            cnt_r <= cnt_r;
         end
      end else begin
         bit_cnt_r <= bit_cnt_r;
      end
   end

   // Output decode from the current state, registered below
   always_comb begin
      ser_out_nx_s   = idle_level(pat_r);
      ser_valid_nx_s = 1'b0;
      busy_nx_s      = 1'b0;
      done_nx_s      = 1'b0;
      case (state_r)
         SEND: begin
            ser_out_nx_s   = piso_msb_s;
            ser_valid_nx_s = 1'b1;
            busy_nx_s      = 1'b1;
         end
         GAP:     busy_nx_s = 1'b1;
         FINISH:  done_nx_s = 1'b1;
         IDLE:    done_nx_s = 1'b0;
         default: done_nx_s = 1'b0;
      endcase
   end

   // Output registers
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         ser_out   <= 1'b0;
         ser_valid <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         ser_out   <= ser_out_nx_s;
         ser_valid <= ser_valid_nx_s;
         busy      <= busy_nx_s;
         done      <= done_nx_s;
      end
   end

endmodule

// File: tb/tb_pattern_sender.sv
// Self-checking bench for pattern_sender: directed and random transfers against a stream model.
module tb_pattern_sender;

`ifdef PATTERN_SENDER_GAP_EN
   localparam int GAP_N = 2;
`else
   localparam int GAP_N = 0;
`endif

   logic       clock = 1'b0;
   logic       rst_n;
   logic       start;
   logic [3:0] pattern;
   logic [3:0] reps;
   logic       ser_out, ser_valid, busy, done;

   int         checks = 0;
   int         errors = 0;
   logic [3:0] prev_pat;

   pattern_sender #(.REPS_W(4), .GAP_LEN(2)) dut (
      .clock     (clock),
      .rst_n     (rst_n),
      .start     (start),
      .pattern   (pattern),
      .reps      (reps),
      .ser_out   (ser_out),
      .ser_valid (ser_valid),
      .busy      (busy),
      .done      (done)
   );

   always #5 clock = ~clock;

   // Compare {ser_out, ser_valid, busy, done} against the expected vector.
   task automatic chk(input string tag, input logic [3:0] exp);
      logic [3:0] obs;
      obs = {ser_out, ser_valid, busy, done};
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed={so,sv,busy,done}=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clock);
         chk($sformatf("idle%0d", i), {~prev_pat[0], 3'b000});
      end
   endtask

   // One transfer starting at a negedge; returns at the negedge inside the done cycle.
   task automatic xfer(input logic [3:0] pat, input logic [3:0] rp, input bit noise);
      logic [3:0] exp_q[$];
      start   = 1'b1;
      pattern = pat;
      reps    = rp;
      @(negedge clock);
      start = 1'b0;
      chk($sformatf("accept p=%b r=%0d", pat, rp), {~prev_pat[0], 3'b000});
      prev_pat = pat;
      for (int r = 0; r < int'(rp); r++) begin
         if (r > 0) begin
            for (int g = 0; g < GAP_N; g++) exp_q.push_back({~pat[0], 3'b010});
         end
         for (int b = 3; b >= 0; b--) exp_q.push_back({pat[b], 3'b110});
      end
      exp_q.push_back({~pat[0], 3'b001});
      for (int i = 0; i < exp_q.size(); i++) begin
         @(negedge clock);
         chk($sformatf("xfer p=%b r=%0d cyc=%0d", pat, rp, i), exp_q[i]);
         if (noise && (i + 3 <= exp_q.size())) begin
            start   = 1'($urandom_range(0, 1));
            pattern = 4'($urandom);
            reps    = 4'($urandom);
         end else begin
            start = 1'b0;
         end
      end
   endtask

   initial begin
      rst_n    = 1'b0;
      start    = 1'b0;
      pattern  = 4'b0000;
      reps     = 4'd0;
      prev_pat = 4'b0001;
      #3;
      chk("reset", 4'b0000);
      @(negedge clock);
      rst_n = 1'b1;
      idle_cycles(5);

      xfer(4'b1011, 4'd1, 1'b0);
      idle_cycles(2);
      xfer(4'b1101, 4'd3, 1'b0);
      idle_cycles(1);
      // Start/inputs toggled during the send must be ignored
      xfer(4'b1011, 4'd2, 1'b1);
      // Back-to-back: start asserted in the done cycle
      xfer(4'b0110, 4'd2, 1'b0);
      xfer(4'b1001, 4'd0, 1'b0);
      idle_cycles(2);
      xfer(4'b1010, 4'd15, 1'b0);
      idle_cycles(1);

      // Reset in the middle of a transfer
      start   = 1'b1;
      pattern = 4'b1011;
      reps    = 4'd2;
      @(negedge clock);
      start = 1'b0;
      chk("mid accept", {~prev_pat[0], 3'b000});
      @(negedge clock);
      chk("mid bit0", 4'b1110);
      @(negedge clock);
      chk("mid bit1", 4'b0110);
      #2 rst_n = 1'b0;
      #1 chk("mid reset", 4'b0000);
      prev_pat = 4'b0001;
      @(negedge clock);
      chk("in reset", 4'b0000);
      rst_n = 1'b1;
      idle_cycles(2);
      xfer(4'b1011, 4'd1, 1'b0);

      for (int t = 0; t < 10; t++) begin
         xfer(4'($urandom), 4'($urandom_range(0, 6)), 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 1) == 1) idle_cycles($urandom_range(1, 3));
      end
      idle_cycles(2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pattern_sender.md
# pattern_sender

Serial pattern transmitter: latches a 4-bit pattern and a repetition count on a start strobe, then shifts the pattern out one bit per clock, MSB (pattern[3]) first, for the requested number of repetitions. It is the transmit-side counterpart of the team's serial pattern detectors and drives their `ser_in` directly in loopback benches and in the lab top level. It signals progress with `busy`, per-bit `ser_valid` and a one-cycle `done` pulse.

## Interface
- `REPS_W`, 4, width of the repetition count.
- `GAP_LEN`, 2, idle bits inserted between repetitions; used only when `PATTERN_SENDER_GAP_EN` is defined; legal range 1..15.

- `clock`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  request; sampled only while `busy`=0.
- `pattern`  in  4  pattern to send, latched on accepted start.
- `reps`  in  REPS_W  repetition count, latched on accepted start.
- `ser_out`  out  1  serial data.
- `ser_valid`  out  1  high while `ser_out` carries a pattern bit.
- `busy`  out  1  transmission in progress.
- `done`  out  1  one-cycle pulse on completion.

## Operation
- FSM states: IDLE, SEND, GAP (GAP only with the macro), FINISH.
- IDLE: `busy`=0. On `start`=1: latch `pattern` and `reps`. If `reps`=0, go to FINISH with no bits sent. Otherwise load the 4-bit shifter, set the repetition counter to `reps`, and go to SEND.
- SEND: each cycle drive the current MSB on `ser_out` with `ser_valid`=1, and shift left. After the 4th bit, decrement the repetition counter. If the count is exhausted, go to FINISH. Otherwise reload the latched pattern and go to GAP (macro on) or stay in SEND (macro off).
- GAP: drive the idle level for `GAP_LEN` cycles with `ser_valid`=0, reload, return to SEND.
- FINISH: `done`=1 and `busy`=0 for exactly one cycle, then return to IDLE. `start` is accepted in FINISH, as in IDLE, to allow back-to-back transfers.
- Idle level: whenever `ser_valid`=0, `ser_out` = ~latched pattern[0]. This matches the detector's pre-fill, so idle bits never complete a false match.
- Input changes to `pattern` and `reps` while `busy`=1 are ignored. `start` while `busy`=1 is ignored.
- The repetition counter is REPS_W bits wide; the maximum `reps` = 2^REPS_W−1 sends that many full patterns. There is no wrap.

## Timing
- Reset (asynchronous, immediate, including mid-transfer): state IDLE, latched pattern 4'b0001. Outputs reset to `ser_out`=0, `ser_valid`=0, `busy`=0, `done`=0.
- All outputs are registered.
- Start is accepted at edge k. `busy` and `ser_valid` rise, and the first bit appears, after edge k+1.
- Each bit is held for exactly one cycle.
- Without gaps, the last bit occupies the cycle after edge k+4·reps, and `done` follows in the next cycle.
- With gaps, add (reps−1)·GAP_LEN cycles to that count.
- With `reps`=0, `done` is high in the cycle after edge k+1; `ser_valid` never rises.

## Configuration
- `PATTERN_SENDER_GAP_EN` defined: the GAP state exists, and `GAP_LEN` idle-level bits separate consecutive repetitions. No gap follows the final repetition.
- Not defined: the GAP state and its counter are not built. Repetitions are sent back-to-back with continuous `ser_valid`. `GAP_LEN` is ignored.

## Structure
- Shared package `pattern_sender_pkg` holds:
  - the state enum (IDLE, SEND, GAP, FINISH),
  - `PATTERN_W`=4,
  - the reset pattern constant 4'b0001.
- One sub-module, `pattern_piso`: a 4-bit parallel-load, shift-left serializer with an asynchronous active-low reset. It mirrors the detector-side shift register.
- Bit and gap counters live in the top-level FSM.

## Test plan
- Reset: hold `rst_n`=0 → all outputs 0. Release, idle 5 cycles → outputs stay 0.
- `pattern`=4'b1011, `reps`=1, pulse `start` → `ser_out` 1,0,1,1 with `ser_valid`=1 for 4 cycles. `done` pulses in cycle 5. `busy` is high in cycles 1–4.
- `pattern`=4'b1101, `reps`=3:
  - Macro off → 12 valid bits 110111011101.
  - Macro on, `GAP_LEN`=2 → 1101,00,1101,00,1101, with `ser_valid`=0 on the gap bits (idle level 0).
- Assert `start` with `pattern`=4'b0000 during the 2nd bit of a 4'b1011 send → ignored, output unchanged. Re-assert `start` in the `done` cycle → new transfer begins the next cycle.
- Reset mid-transfer at bit 2 → outputs 0 immediately. A fresh start after release sends the full pattern.
- `reps`=0 → no `ser_valid`. `done` is high one cycle after the start edge.
- Loopback into the nonoverlapping detector: pattern 4'b0110, `reps`=2 → `found` pulses exactly twice.
